// File: rtl/eth_pcs_params.sv
// Shared constants, state encoding and sync-header helper for the 64b/66b
// PCS block-lock logic.
package eth_pcs_params;

  localparam int SH_TH               = 64;
  localparam int SH_INVAL_TH         = 16;
  localparam int W_SH_TH             = $clog2(SH_TH);
  localparam int W_SH_INVAL_TH       = $clog2(SH_INVAL_TH);
  localparam int W_SYNC              = 2;
  localparam int SLIP_WAIT_BLKS_DEF  = 2;

  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP      = 2'd2,
    SLIP_WAIT = 2'd3
  } lock_state_t;

  // Only the two transition patterns are legal 66b sync headers.
  function automatic logic sh_valid(input logic [W_SYNC-1:0] sh);
    return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_block_lock.sv
// 64b/66b receive block-lock state machine: hunts for sync-header alignment by
// commanding gearbox slips, declares lock after 64 clean headers.
module eth_pcs_block_lock
  import eth_pcs_params::*;
#(
  parameter int SLIP_WAIT_BLKS = SLIP_WAIT_BLKS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_signal_ok,
  input  logic              i_valid,
  input  logic [W_SYNC-1:0] i_sync,
  output logic              o_slip,
  output logic              o_block_lock,
  output logic              o_sh_invalid
);

  localparam int W_WAIT = (SLIP_WAIT_BLKS > 1) ? $clog2(SLIP_WAIT_BLKS) : 1;

  localparam logic [W_SH_TH-1:0]       SH_LAST    = W_SH_TH'(SH_TH - 1);
  localparam logic [W_SH_INVAL_TH-1:0] INVAL_LAST = W_SH_INVAL_TH'(SH_INVAL_TH - 1);
  localparam logic [W_WAIT-1:0]        WAIT_LAST  = W_WAIT'(SLIP_WAIT_BLKS - 1);

  lock_state_t               state;
  logic [W_SH_TH-1:0]        sh_cnt;
  logic [W_SH_INVAL_TH-1:0]  sh_inval_cnt;
  logic [W_WAIT-1:0]         wait_cnt;

  // Slip and invalid strobes default low every cycle so they are true one-cycle
  // pulses; a missing PMA signal wins over any header decision in that cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= LOCK_INIT;
      sh_cnt       <= '0;
      sh_inval_cnt <= '0;
      wait_cnt     <= '0;
      o_block_lock <= 1'b0;
      o_slip       <= 1'b0;
      o_sh_invalid <= 1'b0;
    end else begin
      o_slip       <= 1'b0;
      o_sh_invalid <= 1'b0;
      if (!i_signal_ok) begin
        state        <= LOCK_INIT;
        o_block_lock <= 1'b0;
        sh_cnt       <= '0;
        sh_inval_cnt <= '0;
        wait_cnt     <= '0;
      end else begin
        case (state)
          LOCK_INIT: begin
            o_block_lock <= 1'b0;
            sh_cnt       <= '0;
            sh_inval_cnt <= '0;
            wait_cnt     <= '0;
            state        <= TEST_SH;
          end

          TEST_SH: begin
            if (i_valid) begin
              if (sh_valid(i_sync)) begin
                if (sh_cnt == SH_LAST) begin
                  if (sh_inval_cnt == '0) begin
                    o_block_lock <= 1'b1;
                  end
                  sh_cnt       <= '0;
                  sh_inval_cnt <= '0;
                end else begin
                  sh_cnt <= sh_cnt + W_SH_TH'(1);
                end
              end else begin
                o_sh_invalid <= 1'b1;
                // The 16th invalid header always slips, even in the 64th slot.
                if (!o_block_lock || (sh_inval_cnt == INVAL_LAST)) begin
                  o_block_lock <= 1'b0;
                  o_slip       <= 1'b1;
                  state        <= SLIP;
                end else if (sh_cnt == SH_LAST) begin
                  sh_cnt       <= '0;
                  sh_inval_cnt <= '0;
                end else begin
                  sh_cnt       <= sh_cnt + W_SH_TH'(1);
                  sh_inval_cnt <= sh_inval_cnt + W_SH_INVAL_TH'(1);
                end
              end
            end
          end

          SLIP: begin
            sh_cnt       <= '0;
            sh_inval_cnt <= '0;
            wait_cnt     <= '0;
            state        <= SLIP_WAIT;
          end

          SLIP_WAIT: begin
            if (i_valid) begin
              if (wait_cnt == WAIT_LAST) begin
                wait_cnt <= '0;
                state    <= TEST_SH;
              end else begin
                wait_cnt <= wait_cnt + W_WAIT'(1);
              end
            end
          end

          default: state <= LOCK_INIT;
        endcase
      end
    end
  end

endmodule

// File: doc/eth_pcs_block_lock.md
ETH_PCS_BLOCK_LOCK -- requirements
Module: eth_pcs_block_lock

Interface
REQ-001 Parameter SLIP_WAIT_BLKS, default 2: number of i_valid strobes ignored after each slip while the RX gearbox realigns.
REQ-002 Port i_clk, input, 1: the only clock; all state changes on its rising edge.
REQ-003 Port i_rst, input, 1: asynchronous, active-high reset.
REQ-004 Port i_signal_ok, input, 1: PMA signal present; low forces loss of lock.
REQ-005 Port i_valid, input, 1: strobe; i_sync carries one new block's sync header this cycle.
REQ-006 Port i_sync, input, W_SYNC: received sync header, in bit order after RX gearbox reversal.
REQ-007 Port o_slip, output, 1: registered one-cycle pulse commanding the RX gearbox to shift alignment by one bit.
REQ-008 Port o_block_lock, output, 1: registered block-lock status.
REQ-009 Port o_sh_invalid, output, 1: registered one-cycle pulse flagging an invalid header sampled while not in slip wait.

Function
REQ-010 Header valid when i_sync equals SYNC_DATA or SYNC_CTRL; 2'b00 and 2'b11 are invalid.
REQ-011 States: LOCK_INIT, TEST_SH, SLIP, SLIP_WAIT.
REQ-012 LOCK_INIT: o_block_lock=0; sh_cnt=0; sh_inval_cnt=0; next cycle TEST_SH if i_signal_ok=1, else stay.
REQ-013 Counters: sh_cnt counts 0..SH_TH-1 (W_SH_TH bits); sh_inval_cnt counts 0..SH_INVAL_TH-1 (W_SH_INVAL_TH bits); neither wraps silently.
REQ-014 TEST_SH, i_valid=0: no state or counter change.
REQ-015 TEST_SH, valid header: if sh_cnt=SH_TH-1 (64th header) and sh_inval_cnt=0, set o_block_lock=1 and clear both counters.
REQ-016 In the same 64th-header case with sh_inval_cnt>0, clear both counters; o_block_lock unchanged.
REQ-017 Otherwise, on a valid header, sh_cnt increments.
REQ-018 TEST_SH, invalid header: o_sh_invalid pulses in the next cycle.
REQ-019 Invalid header with o_block_lock=0: go to SLIP.
REQ-020 Invalid header with o_block_lock=1 and sh_inval_cnt=SH_INVAL_TH-1 (16th invalid in window): clear o_block_lock and go to SLIP.
REQ-021 Invalid header with o_block_lock=1, fewer than 16 invalids and sh_cnt=SH_TH-1: clear both counters and stay locked.
REQ-022 Otherwise, on an invalid header, increment both counters.
REQ-023 SLIP: o_slip=1 for exactly one cycle; clear both counters and the wait counter; next state SLIP_WAIT.
REQ-024 SLIP_WAIT: count i_valid strobes and ignore their headers; after SLIP_WAIT_BLKS strobes go to TEST_SH.
REQ-025 Decision latency: the header sampled in cycle N is reflected in o_block_lock, o_slip or o_sh_invalid at cycle N+1.
REQ-026 i_signal_ok=0 in any state: next cycle LOCK_INIT with o_block_lock=0 and o_slip=0; this overrides any simultaneous i_valid decision.
REQ-027 A lock loss with exactly 16 invalid headers in the 64th slot takes the slip path of REQ-020, not the counter reset of REQ-021.
REQ-028 o_slip is never asserted on two consecutive cycles.
REQ-029 o_slip is never asserted while o_block_lock=1.

Reset
REQ-030 i_rst=1 asynchronously sets state=LOCK_INIT, all counters=0, o_block_lock=0, o_slip=0 and o_sh_invalid=0.
REQ-031 Reset mid-operation, including during SLIP or SLIP_WAIT, discards the pending wait; no o_slip pulse follows reset release.

Structure
REQ-032 The state enum typedef, SLIP_WAIT_BLKS default and header-valid function live in package eth_pcs_params; SH_TH, SH_INVAL_TH, W_SH_TH, W_SH_INVAL_TH, W_SYNC, SYNC_DATA and SYNC_CTRL are reused from it.
REQ-033 Single flat module, no sub-modules; one FSM and three counters (sh, invalid, slip wait).

Verification
REQ-034 Reset, i_signal_ok=1, 64 valid headers -> o_block_lock=1 one cycle after the 64th strobe; o_slip never asserted.
REQ-035 Unlocked, header 2'b11 at strobe 10 -> o_sh_invalid and o_slip each pulse once; the next 2 strobes are ignored; after 64 further valid headers -> lock.
REQ-036 Locked, 15 invalid headers within a 64-header window -> lock held, counters reset at the 64th header; repeat with 16 invalids -> o_block_lock=0 and one o_slip one cycle after the 16th.
REQ-037 Locked, i_signal_ok dropped for 1 cycle together with an i_valid -> o_block_lock=0 next cycle, no o_slip; relock needs 64 valid headers.
REQ-038 Assert i_rst during SLIP_WAIT -> all outputs 0 asynchronously; after release, sequence REQ-034 locks normally.
REQ-039 Random headers with i_valid gaps -> assertions REQ-028 and REQ-029 hold, and o_sh_invalid matches a reference count.
